smaesh_out_serializer: RTL

Downstream stage of the masked AES top: it consumes the 128*d-bit shared ciphertext block over a valid/ready stream and emits it as a stream of 32-bit share words. It tags each word with its share index, word index and last-of-block flag, so a 32-bit bus or DMA can drain results. Shares are never recombined. Buffered share material is zeroized once it has been emitted.

---
 rtl/smaesh_out_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/smaesh_out_serializer.sv
// Serializes a 128*d-bit shared ciphertext block into 32-bit share words tagged with share/word index.
// Optional SMAESH_OUT_SERIALIZER_SKID_EN adds a pending block register so in_ready has no out_ready path.
module smaesh_out_serializer #(
  parameter int d  = 2,
  parameter int SW = ($clog2(d) < 1) ? 1 : $clog2(d)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [128*d-1:0]  in_shares_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [SW-1:0]     out_share_idx,
  output logic [1:0]        out_word_idx,
  output logic              out_last
);

  localparam int BW = 128 * d;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t          state;
  logic [BW-1:0]   buffer;
  logic [SW-1:0]   share_cnt;
  logic [1:0]      word_cnt;
  logic            out_fire;
  logic            in_fire;
  logic            is_last;

  // The buffer drains through zero-fill shifts, so an idle serializer already drives zero data.
  assign out_valid     = (state == SEND);
  assign is_last       = out_valid && (share_cnt == SW'(d - 1)) && (word_cnt == 2'd3);
  assign out_last      = is_last;
  assign out_data      = buffer[31:0];
  assign out_share_idx = share_cnt;
  assign out_word_idx  = word_cnt;
  assign out_fire      = out_valid && out_ready;
  assign in_fire       = in_valid && in_ready;

`ifdef SMAESH_OUT_SERIALIZER_SKID_EN
  logic [BW-1:0] pend_buf;
  logic          pend_full;

  assign in_ready = !pend_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data registers are reset too; they hold key-dependent shares that must not survive a reset.
      state     <= EMPTY;
      buffer    <= '0;
      pend_buf  <= '0;
      pend_full <= 1'b0;
      share_cnt <= '0;
      word_cnt  <= '0;
    end else if (out_fire) begin
      if (is_last) begin
        share_cnt <= '0;
        word_cnt  <= '0;
        if (pend_full) begin
          buffer    <= pend_buf;
          pend_buf  <= '0;
          pend_full <= 1'b0;
        end else if (in_fire) begin
          buffer <= in_shares_data;
        end else begin
          state  <= EMPTY;
          buffer <= '0;
        end
      end else begin
        buffer   <= {32'd0, buffer[BW-1:32]};
        word_cnt <= word_cnt + 2'd1;
        if (word_cnt == 2'd3) share_cnt <= share_cnt + SW'(1);
        if (in_fire) begin
          pend_buf  <= in_shares_data;
          pend_full <= 1'b1;
        end
      end
    end else if (in_fire) begin
      if (state == EMPTY) begin
        state     <= SEND;
        buffer    <= in_shares_data;
        share_cnt <= '0;
        word_cnt  <= '0;
      end else begin
        pend_buf  <= in_shares_data;
        pend_full <= 1'b1;
      end
    end
  end
`else
  // Accepting on the last-word handshake keeps consecutive blocks bubble-free.
  assign in_ready = (state == EMPTY) || (out_fire && is_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data registers are reset too; they hold key-dependent shares that must not survive a reset.
      state     <= EMPTY;
      buffer    <= '0;
      share_cnt <= '0;
      word_cnt  <= '0;
    end else if (in_fire) begin
      state     <= SEND;
      buffer    <= in_shares_data;
      share_cnt <= '0;
      word_cnt  <= '0;
    end else if (out_fire) begin
      if (is_last) begin
        state     <= EMPTY;
        buffer    <= '0;
        share_cnt <= '0;
        word_cnt  <= '0;
      end else begin
        buffer   <= {32'd0, buffer[BW-1:32]};
        word_cnt <= word_cnt + 2'd1;
        if (word_cnt == 2'd3) share_cnt <= share_cnt + SW'(1);
      end
    end
  end
`endif

endmodule
